// File: rtl/gray_count_source.sv
// Handshaked binary/gray count generator feeding the 4-bit gray converter.
// Supports up/down counting, parallel load, programmable terminal count and one-shot mode.
module gray_count_source #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int ONE_SHOT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dir,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             wrap,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_COUNT);

  state_t           state_p1, state_p0;
  logic [WIDTH-1:0] cnt_p0;
  logic             wrap_p0;
  logic             xfer_p0;
  logic             terminal_p0;

  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > MAX_W) ? MAX_W : v;
  endfunction

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic up);
    if (up) return (v == MAX_W) ? '0 : v + WIDTH'(1);
    else    return (v == '0) ? MAX_W : v - WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // p0: next-state decode; command priority is load > stop > start > advance
  always_comb begin
    state_p0    = state_p1;
    cnt_p0      = count_bin;
    wrap_p0     = 1'b0;
    xfer_p0     = (state_p1 == RUN) && out_ready;
    terminal_p0 = dir ? (count_bin == MAX_W) : (count_bin == '0);
    if (load && (state_p1 != RUN)) begin
      cnt_p0   = sat_load(load_value);
      state_p0 = IDLE;
    end else begin
      if (xfer_p0) begin
        // In one-shot mode the terminal beat is consumed but the count parks on it
        if ((ONE_SHOT != 0) && terminal_p0) begin
          state_p0 = DONE;
        end else begin
          cnt_p0  = step(count_bin, dir);
          wrap_p0 = terminal_p0;
        end
      end
      if (stop && (state_p1 == RUN)) begin
        state_p0 = IDLE;
      end else if (start && (state_p1 == IDLE)) begin
        state_p0 = RUN;
      end else if (start && (state_p1 == DONE)) begin
        state_p0 = RUN;
        cnt_p0   = dir ? '0 : MAX_W;
      end
    end
  end

  // p1: registered state and outputs, binary and gray updated on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1   <= IDLE;
      count_bin  <= '0;
      count_gray <= '0;
      wrap       <= 1'b0;
    end else begin
      state_p1   <= state_p0;
      count_bin  <= cnt_p0;
      count_gray <= to_gray(cnt_p0);
      wrap       <= wrap_p0;
    end
  end

  assign out_valid = (state_p1 == RUN);
  assign busy      = (state_p1 == RUN);

endmodule
